// File: rtl/rx_cmd_dispatcher_if.sv
// Dispatcher-side signal bundle: packet receiver, receive buffer read port,
// execution unit handshake and status response channel.
interface rx_cmd_dispatcher_if #(
  parameter int unsigned AW = 8
);
  logic          rx_done;
  logic [7:0]    cmd_rx;
  logic [7:0]    len_rx;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] ex_rd_addr;
  logic          op_valid;
  logic [7:0]    op_cmd;
  logic [7:0]    op_len;
  logic          op_ready;
  logic          op_done;
  logic          op_err;
  logic          rsp_valid;
  logic [7:0]    rsp_code;
  logic          rsp_ready;
  logic          busy;
  logic [7:0]    drop_cnt;

  modport master (
    input  rx_done, cmd_rx, len_rx, rd_data, ex_rd_addr,
           op_ready, op_done, op_err, rsp_ready,
    output rd_addr, op_valid, op_cmd, op_len, rsp_valid, rsp_code, busy, drop_cnt
  );

  modport slave (
    output rx_done, cmd_rx, len_rx, rd_data, ex_rd_addr,
           op_ready, op_done, op_err, rsp_ready,
    input  rd_addr, op_valid, op_cmd, op_len, rsp_valid, rsp_code, busy, drop_cnt
  );
endinterface

// File: rtl/rx_cmd_dispatcher.sv
// Packet-level controller: validates a received command, checksums its payload,
// hands it to the execution unit under a timeout and returns one status code.
module rx_cmd_dispatcher #(
  parameter int unsigned NUMBER       = 256,
  parameter int unsigned CMD_MAX      = 8,
  parameter int unsigned EXEC_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  rx_cmd_dispatcher_if.master bus
);

  localparam int unsigned AW = (NUMBER > 1) ? $clog2(NUMBER) : 1;
  localparam int unsigned TW = $clog2(EXEC_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(EXEC_TIMEOUT - 1);

  localparam logic [7:0] RSP_OK      = 8'h00;
  localparam logic [7:0] RSP_BAD_CMD = 8'hE1;
  localparam logic [7:0] RSP_BAD_SUM = 8'hE2;
  localparam logic [7:0] RSP_EXE_ERR = 8'hE3;
  localparam logic [7:0] RSP_TMO     = 8'hE5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPATCH,
    ST_EXEC,
    ST_RESP
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [7:0]    r_cmd,      w_cmd_nxt;
  logic [7:0]    r_len,      w_len_nxt;
  logic [7:0]    r_cnt,      w_cnt_nxt;
  logic [7:0]    r_sum,      w_sum_nxt;
  logic [TW-1:0] r_timer,    w_timer_nxt;
  logic [7:0]    r_rsp_code, w_rsp_code_nxt;
  logic [7:0]    r_drop_cnt, w_drop_cnt_nxt;
  logic          r_op_valid, w_op_valid_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic          r_busy,     w_busy_nxt;
  logic [7:0]    w_sum_add;
  logic          w_cmd_bad;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_timer     <= '0;
      r_rsp_code  <= '0;
      r_drop_cnt  <= '0;
      r_op_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sum       <= w_sum_nxt;
      r_timer     <= w_timer_nxt;
      r_rsp_code  <= w_rsp_code_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_op_valid  <= w_op_valid_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign w_cmd_bad = (bus.cmd_rx == 8'h00) || (32'(bus.cmd_rx) > CMD_MAX);
  assign w_sum_add = r_sum + bus.rd_data;

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_nxt      = r_cmd;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_sum_nxt      = r_sum;
    w_timer_nxt    = r_timer;
    w_rsp_code_nxt = r_rsp_code;
    w_drop_cnt_nxt = r_drop_cnt;

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_done) begin
          w_cmd_nxt = bus.cmd_rx;
          w_len_nxt = bus.len_rx;
          w_cnt_nxt = '0;
          w_sum_nxt = '0;
          if (w_cmd_bad) begin
            w_state_nxt    = ST_RESP;
            w_rsp_code_nxt = RSP_BAD_CMD;
          end else if (bus.len_rx == 8'h00) begin
            w_state_nxt = ST_DISPATCH;
          end else begin
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        // r_cnt is the address in flight; data for r_cnt-1 arrives this cycle
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt != 8'h00) w_sum_nxt = w_sum_add;
        if (r_cnt == r_len) begin
          if (w_sum_add == 8'h00) begin
            w_state_nxt = ST_DISPATCH;
          end else begin
            w_state_nxt    = ST_RESP;
            w_rsp_code_nxt = RSP_BAD_SUM;
          end
        end
      end
      ST_DISPATCH: begin
        if (bus.op_ready) begin
          w_state_nxt = ST_EXEC;
          w_timer_nxt = '0;
        end
      end
      ST_EXEC: begin
        // Completion takes priority over an expiring timer
        if (bus.op_done) begin
          w_state_nxt    = ST_RESP;
          w_rsp_code_nxt = bus.op_err ? RSP_EXE_ERR : RSP_OK;
        end else if (r_timer == TMO_LAST) begin
          w_state_nxt    = ST_RESP;
          w_rsp_code_nxt = RSP_TMO;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (bus.rx_done && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF))
      w_drop_cnt_nxt = r_drop_cnt + 8'd1;

    w_op_valid_nxt  = (w_state_nxt == ST_DISPATCH);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  // Execution unit owns the buffer port once the command is offered
  assign bus.rd_addr = ((r_state == ST_DISPATCH) || (r_state == ST_EXEC)) ?
                       bus.ex_rd_addr : AW'(r_cnt);

  assign bus.op_valid  = r_op_valid;
  assign bus.op_cmd    = r_cmd;
  assign bus.op_len    = r_len;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_code  = r_rsp_code;
  assign bus.busy      = r_busy;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_rx_cmd_dispatcher.sv
// Self-checking bench for rx_cmd_dispatcher: expected status codes are queued
// as packets are sent and compared when the response handshake happens.
module tb_rx_cmd_dispatcher;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_cmd_dispatcher_if #(.AW(8)) bus();

  rx_cmd_dispatcher #(
    .NUMBER(256),
    .CMD_MAX(8),
    .EXEC_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  int         n_rsp    = 0;
  bit         op_seen  = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [256];

  // Receive buffer: registered read, one cycle latency
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      check_eq("rsp_q_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) check_eq("rsp_code", 32'(bus.rsp_code), 32'(exp_q.pop_front()));
    end
    if (bus.op_valid) op_seen = 1'b1;
  end

  task automatic chk_rst_outputs();
    check_eq("rst_busy",      32'(bus.busy),      32'd0);
    check_eq("rst_op_valid",  32'(bus.op_valid),  32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_op_cmd",    32'(bus.op_cmd),    32'd0);
    check_eq("rst_op_len",    32'(bus.op_len),    32'd0);
    check_eq("rst_rsp_code",  32'(bus.rsp_code),  32'd0);
    check_eq("rst_rd_addr",   32'(bus.rd_addr),   32'd0);
    check_eq("rst_drop_cnt",  32'(bus.drop_cnt),  32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle T+1
  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] len);
    bus.rx_done = 1'b1;
    bus.cmd_rx  = cmd;
    bus.len_rx  = len;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic wait_op();
    for (int i = 0; i < 60; i++) begin
      if (bus.op_valid) break;
      @(negedge clk);
    end
    check_eq("op_valid_seen", 32'(bus.op_valid), 32'd1);
  endtask

  task automatic pulse_done(input int dly, input logic err);
    repeat (dly) @(negedge clk);
    bus.op_done = 1'b1;
    bus.op_err  = err;
    @(negedge clk);
    bus.op_done = 1'b0;
    bus.op_err  = 1'b0;
    check_eq("rsp_after_done", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 100; i++) begin
      if (n_rsp != n0) break;
      @(negedge clk);
      #1;
    end
    check_eq("rsp_count", 32'(n_rsp), 32'(n0 + 1));
    @(negedge clk);
    check_eq("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFA;
    bus.rx_done = 1'b0; bus.cmd_rx = 8'h00; bus.len_rx = 8'h00;
    bus.ex_rd_addr = 8'h00; bus.op_ready = 1'b1; bus.op_done = 1'b0;
    bus.op_err = 1'b0; bus.rsp_ready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst_outputs();
    reset = 1'b1;
    @(negedge clk);

    // Good packet with checksum: op_valid at T+6, addresses 0..3
    exp_q.push_back(8'h00);
    n0 = n_rsp;
    send_pkt(8'h02, 8'd4);
    check_eq("busy_t1", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq("chk_rd_addr", 32'(bus.rd_addr), 32'(k));
      @(negedge clk);
    end
    check_eq("op_valid_t5", 32'(bus.op_valid), 32'd0);
    @(negedge clk);
    check_eq("op_valid_t6", 32'(bus.op_valid), 32'd1);
    check_eq("op_cmd",      32'(bus.op_cmd),   32'h02);
    check_eq("op_len",      32'(bus.op_len),   32'd4);
    @(negedge clk);
    check_eq("op_valid_drop", 32'(bus.op_valid), 32'd0);
    pulse_done(10, 1'b0);
    wait_rsp(n0);

    // Bad checksum: E2 at T+5, no op offered
    op_seen = 1'b0;
    exp_q.push_back(8'hE2);
    n0 = n_rsp;
    send_pkt(8'h02, 8'd3);
    repeat (3) @(negedge clk);
    check_eq("badsum_rsp_t4", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("badsum_rsp_t5", 32'(bus.rsp_valid), 32'd1);
    wait_rsp(n0);

    // Illegal command codes just below and above the legal range
    for (int j = 0; j < 2; j++) begin
      logic [7:0] c;
      c = (j == 0) ? 8'h00 : 8'h09;
      exp_q.push_back(8'hE1);
      n0 = n_rsp;
      send_pkt(c, 8'd4);
      check_eq("badcmd_rsp_t1", 32'(bus.rsp_valid), 32'd1);
      check_eq("badcmd_op_cmd", 32'(bus.op_cmd),    32'(c));
      wait_rsp(n0);
    end
    check_eq("no_op_offered", 32'(op_seen), 32'd0);

    // len=0, drops during EXEC, rd_addr forwarding
    exp_q.push_back(8'h00);
    n0 = n_rsp;
    send_pkt(8'h03, 8'd0);
    check_eq("len0_op_t1", 32'(bus.op_valid), 32'd1);
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      send_pkt(8'h07, 8'd5);
      check_eq("drop_cnt",     32'(bus.drop_cnt), 32'(i));
      check_eq("drop_op_cmd",  32'(bus.op_cmd),   32'h03);
      check_eq("drop_op_len",  32'(bus.op_len),   32'd0);
    end
    bus.ex_rd_addr = 8'h33; #1;
    check_eq("ex_rd_addr_a", 32'(bus.rd_addr), 32'h33);
    bus.ex_rd_addr = 8'hC4; #1;
    check_eq("ex_rd_addr_b", 32'(bus.rd_addr), 32'hC4);
    pulse_done(1, 1'b0);
    bus.ex_rd_addr = 8'h00;
    wait_rsp(n0);
    repeat (5) @(negedge clk);
    check_eq("single_rsp", 32'(n_rsp), 32'(n0 + 1));

    // Highest legal code, late op_ready, execution error
    bus.op_ready = 1'b0;
    exp_q.push_back(8'hE3);
    n0 = n_rsp;
    send_pkt(8'h08, 8'd4);
    wait_op();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_op_valid", 32'(bus.op_valid), 32'd1);
      check_eq("hold_op_cmd",   32'(bus.op_cmd),   32'h08);
      check_eq("hold_op_len",   32'(bus.op_len),   32'd4);
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    check_eq("late_op_valid_drop", 32'(bus.op_valid), 32'd0);
    pulse_done(2, 1'b1);
    wait_rsp(n0);

    // Timeout: EXEC lasts exactly TMO cycles, then E5
    exp_q.push_back(8'hE5);
    n0 = n_rsp;
    send_pkt(8'h01, 8'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      n++;
    end
    check_eq("timeout_cycles", 32'(n), 32'(TMO));
    wait_rsp(n0);

    // op_done in the last EXEC cycle beats the timeout
    exp_q.push_back(8'h00);
    n0 = n_rsp;
    send_pkt(8'h01, 8'd0);
    pulse_done(TMO, 1'b0);
    wait_rsp(n0);

    // drop_cnt saturation while the response is stalled
    bus.rsp_ready = 1'b0;
    exp_q.push_back(8'hE1);
    n0 = n_rsp;
    send_pkt(8'h00, 8'd0);
    for (int i = 0; i < 260; i++) begin
      send_pkt(8'h07, 8'd1);
      @(negedge clk);
    end
    check_eq("drop_cnt_sat",   32'(bus.drop_cnt),  32'hFF);
    check_eq("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("stall_rsp_code",  32'(bus.rsp_code),  32'hE1);
    bus.rsp_ready = 1'b1;
    wait_rsp(n0);

    // Reset in CHECK: clean outputs, no stale response, then normal packet
    exp_q.push_back(8'h00);
    n0 = n_rsp;
    send_pkt(8'h02, 8'd4);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_rst_outputs();
    repeat (3) @(negedge clk);
    check_eq("rst_hold_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("no_stale_rsp", 32'(n_rsp), 32'(n0));
    exp_q.push_back(8'h00);
    n0 = n_rsp;
    send_pkt(8'h02, 8'd4);
    wait_op();
    @(negedge clk);
    pulse_done(3, 1'b0);
    wait_rsp(n0);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
